comp_mult_arbiter: RTL and testbench
====================================

Name: comp_mult_arbiter

Overview:
Round-robin arbiter that shares one comp_mult_wrapper instance among NO_REQ requesters. It issues each granted operand set to the multiplier and records the requester index in an in-order tag FIFO. Each result the multiplier returns is routed back to the requester that issued the matching operands. It sits between the requester agents and comp_mult_wrapper, and uses the same val/rdy handshake on both sides.

Parameters:
DWIDTH, 8, operand component width, matches comp_mult_wrapper DWIDTH
NO_REQ, 4, number of requesters (2..8)
RES_W, 2*DWIDTH+1, width of one result component (xr or yr)
MAX_OUTST, 4, tag FIFO depth = max in-flight operations (power of 2, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  hw async reset, active low
sw_rst  input  1  sw sync reset, active high
req_val  input  NO_REQ  per-requester operands valid
req_rdy  output  NO_REQ  per-requester operands accepted
req_data  input  NO_REQ*4*DWIDTH  requester i operands {x1,x2,y1,y2} at slice i
rsp_val  output  NO_REQ  per-requester result valid
rsp_rdy  input  NO_REQ  per-requester result ready
rsp_data  output  2*RES_W  result {xr,yr}, broadcast to all requesters
m_op_val  output  1  to multiplier op_val
m_op_rdy  input  1  from multiplier op_rdy
m_op_data  output  4*DWIDTH  to multiplier op_data
m_res_val  input  1  from multiplier res_val
m_res_rdy  output  1  to multiplier res_rdy
m_res_data  input  2*RES_W  from multiplier res_data
outst_cnt  output  clog2(MAX_OUTST)+1  operations in flight
err_unexp  output  1  sticky: result arrived with no operation outstanding

Behaviour:
- Reset: rst_n low (async) or sw_rst high at a clk edge clears:
  - rr pointer to 0, grant lock, tag FIFO pointers, outst_cnt, err_unexp.
  - All outputs are 0 during and immediately after reset.
- Issue side:
  - Eligible = req_val != 0 and FIFO not full.
  - Issue is blocked when full, even if a pop occurs in the same cycle (no bypass).
- Round-robin grant:
  - Search starts at index rr_ptr, wraps from NO_REQ-1 to 0; first set req_val wins.
  - Grant is combinational when unlocked.
- m_op_val = eligible; m_op_data = req_data slice of the granted index.
- req_rdy[g] = m_op_rdy & m_op_val for the granted g only; all other req_rdy bits are 0.
- m_op_val never depends on m_op_rdy.
- Grant lock (states UNLOCKED / LOCKED):
  - UNLOCKED -> LOCKED when m_op_val=1 and m_op_rdy=0; the locked index is registered.
  - LOCKED holds the same grant, ignoring new higher-priority requests.
  - LOCKED -> UNLOCKED on the m_op handshake.
  - Requesters must hold req_val and req_data stable until req_rdy.
- On m_op handshake (m_op_val & m_op_rdy), all in the same edge:
  - Push granted index into the tag FIFO.
  - rr_ptr <= (g+1) mod NO_REQ.
  - outst_cnt increments.
- Return side:
  - The multiplier returns results in issue order; head tag h = FIFO head.
  - rsp_val[i] = m_res_val & !empty & (h==i).
  - rsp_data = m_res_data combinationally, zero added latency.
  - m_res_rdy = !empty & rsp_rdy[h]. Stalled rsp_rdy[h] backpressures the multiplier; other requesters' rsp_rdy are ignored.
- On m_res handshake: pop the FIFO and decrement outst_cnt.
- Simultaneous push and pop: outst_cnt unchanged, both pointers advance.
- Unexpected result: m_res_val=1 while FIFO empty.
  - m_res_rdy stays 0 and all rsp_val stay 0.
  - err_unexp sets on the next edge and stays set until reset.
- sw_rst mid-operation: all in-flight tags are discarded. The multiplier's own sw_rst must be driven by the same signal, so no stale results return.
- Issue-to-response latency is the multiplier's latency only; the arbiter adds no registers in the data path.

Test Plan:
- Single requester: req 2 sends {x1=3,x2=2,y1=4,y2=5} -> m_op_data equals req 2 slice and req_rdy=0100. Result returns on rsp_val[2] only; outst_cnt goes 0->1->0.
- Fairness: all 4 req_val held high for 8 issues, rr_ptr=0 at start -> grant order 0,1,2,3,0,1,2,3; results return on rsp_val in the same order.
- Grant lock: m_op_rdy=0 for 3 cycles while req 1 is granted, then req 0 asserts -> grant stays 1 until the handshake, then goes to 2 or 0 per rr_ptr=2.
- Full FIFO: m_res_rdy path stalled with rsp_rdy=0, issue 4 ops -> outst_cnt=4 and m_op_val=0 with req_val still high. Release rsp_rdy -> one pop, then issue resumes the next cycle.
- Head stall: head tag=3 with rsp_rdy[3]=0 and rsp_rdy[0]=1 -> m_res_rdy=0 and no pop until rsp_rdy[3]=1.
- Reset/error: m_res_val=1 with empty FIFO -> err_unexp=1 the next cycle and m_res_rdy=0. sw_rst pulse with 2 ops outstanding -> outst_cnt=0, err_unexp=0, rr_ptr=0.

Source files
------------

// File: rtl/comp_mult_arbiter.sv
// Round-robin arbiter sharing one comp_mult_wrapper among NO_REQ requesters.
// Issue order is kept in a tag FIFO so each in-order result goes back to its owner.
module comp_mult_arbiter #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned NO_REQ    = 4,
  parameter int unsigned RES_W     = 2*DWIDTH+1,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sw_rst,
  input  logic [NO_REQ-1:0]            req_val,
  output logic [NO_REQ-1:0]            req_rdy,
  input  logic [NO_REQ*4*DWIDTH-1:0]   req_data,
  output logic [NO_REQ-1:0]            rsp_val,
  input  logic [NO_REQ-1:0]            rsp_rdy,
  output logic [2*RES_W-1:0]           rsp_data,
  output logic                         m_op_val,
  input  logic                         m_op_rdy,
  output logic [4*DWIDTH-1:0]          m_op_data,
  input  logic                         m_res_val,
  output logic                         m_res_rdy,
  input  logic [2*RES_W-1:0]           m_res_data,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_unexp
);

  localparam int unsigned OPW = 4*DWIDTH;
  localparam int unsigned TW  = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;
  localparam int unsigned PW  = $clog2(MAX_OUTST);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  lock_e          r_lock_st;
  logic [TW-1:0]  r_lock_idx;
  logic [TW-1:0]  r_rr_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_cnt;
  logic           r_err;
  logic [TW-1:0]  r_tags [MAX_OUTST];

  logic           w_run;
  logic [TW-1:0]  w_rr_idx;
  logic [TW-1:0]  w_cand;
  logic [TW-1:0]  w_grant;
  logic [TW-1:0]  w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_op_val;
  logic           w_push;
  logic           w_res_rdy;
  logic           w_pop;

  // Outputs are forced low while either reset is active.
  assign w_run = rst_n & ~sw_rst;

  // Round-robin search: scan offsets high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    w_rr_idx = '0;
    w_cand   = '0;
    for (int k = int'(NO_REQ) - 1; k >= 0; k--) begin
      w_cand = TW'((int'(r_rr_ptr) + k) % int'(NO_REQ));
      if (req_val[w_cand]) begin
        w_rr_idx = w_cand;
      end
    end
  end

  assign w_grant   = (r_lock_st == LOCKED) ? r_lock_idx : w_rr_idx;
  assign w_full    = (r_cnt == CW'(MAX_OUTST));
  assign w_empty   = (r_cnt == '0);
  assign w_op_val  = w_run & (|req_val) & ~w_full;
  assign w_push    = w_op_val & m_op_rdy;
  assign w_head    = r_tags[r_rd_ptr];
  assign w_res_rdy = w_run & ~w_empty & rsp_rdy[w_head];
  assign w_pop     = m_res_val & w_res_rdy;

  assign m_op_val  = w_op_val;
  assign m_op_data = w_op_val ? req_data[OPW*int'(w_grant) +: OPW] : '0;
  assign m_res_rdy = w_res_rdy;
  assign rsp_data  = w_run ? m_res_data : '0;
  assign outst_cnt = w_run ? r_cnt : '0;
  assign err_unexp = w_run & r_err;

  // One-hot handshake and response-valid decode.
  always_comb begin
    req_rdy = '0;
    rsp_val = '0;
    if (w_push) begin
      req_rdy[w_grant] = 1'b1;
    end
    if (w_run && m_res_val && !w_empty) begin
      rsp_val[w_head] = 1'b1;
    end
  end

  // Grant lock, rr pointer, tag FIFO and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_st  <= UNLOCKED;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTST); i++) r_tags[i] <= '0;
    end else if (sw_rst) begin
      r_lock_st  <= UNLOCKED;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_lock_st)
        UNLOCKED: begin
          if (w_op_val && !m_op_rdy) begin
            r_lock_st  <= LOCKED;
            r_lock_idx <= w_grant;
          end
        end
        LOCKED: begin
          if (w_push) r_lock_st <= UNLOCKED;
        end
        default: r_lock_st <= UNLOCKED;
      endcase

      if (w_push) begin
        r_tags[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
        r_rr_ptr         <= (w_grant == TW'(NO_REQ - 1)) ? '0 : w_grant + TW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (m_res_val && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comp_mult_arbiter.sv
// Bench for comp_mult_arbiter: directed cycle table plus randomized traffic vs a queue model.
module tb_comp_mult_arbiter;
  localparam int NR = 4;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_rst = 1'b0;
  logic [3:0]    req_val = '0;
  logic [3:0]    req_rdy;
  logic [127:0]  req_data = '0;
  logic [3:0]    rsp_val;
  logic [3:0]    rsp_rdy = '0;
  logic [33:0]   rsp_data;
  logic          m_op_val;
  logic          m_op_rdy = 1'b0;
  logic [31:0]   m_op_data;
  logic          m_res_val = 1'b0;
  logic          m_res_rdy;
  logic [33:0]   m_res_data = '0;
  logic [2:0]    outst_cnt;
  logic          err_unexp;

  int total = 0;
  int bad   = 0;

  comp_mult_arbiter #(.DWIDTH(8), .NO_REQ(NR), .RES_W(17), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_data(req_data),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .m_op_val(m_op_val), .m_op_rdy(m_op_rdy), .m_op_data(m_op_data),
    .m_res_val(m_res_val), .m_res_rdy(m_res_rdy), .m_res_data(m_res_data),
    .outst_cnt(outst_cnt), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slice(input int g);
    logic [127:0] d;
    d = req_data >> (32 * g);
    return d[31:0];
  endfunction

  task automatic check_out(input string tag, input logic ev, input logic [3:0] erdy,
                           input logic [31:0] edata, input logic [3:0] esv, input logic eres,
                           input logic [33:0] ersp, input logic [2:0] ecnt, input logic eerr);
    chk({tag, ".m_op_val"},  64'(m_op_val),  64'(ev));
    chk({tag, ".req_rdy"},   64'(req_rdy),   64'(erdy));
    if (ev) chk({tag, ".m_op_data"}, 64'(m_op_data), 64'(edata));
    chk({tag, ".rsp_val"},   64'(rsp_val),   64'(esv));
    chk({tag, ".m_res_rdy"}, 64'(m_res_rdy), 64'(eres));
    chk({tag, ".rsp_data"},  64'(rsp_data),  64'(ersp));
    chk({tag, ".outst_cnt"}, 64'(outst_cnt), 64'(ecnt));
    chk({tag, ".err_unexp"}, 64'(err_unexp), 64'(eerr));
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       opr;
    logic       resv;
    logic [3:0] rr;
    logic       sw;
    logic       ev;
    logic [3:0] erdy;
    int         eg;
    logic [3:0] esv;
    logic       eres;
    logic [2:0] ecnt;
    logic       eerr;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rv, input logic opr, input logic resv,
                              input logic [3:0] rr, input logic sw, input logic ev,
                              input logic [3:0] erdy, input int eg, input logic [3:0] esv,
                              input logic eres, input logic [2:0] ecnt, input logic eerr);
    vec_t v;
    v.rv = rv; v.opr = opr; v.resv = resv; v.rr = rr; v.sw = sw; v.ev = ev;
    v.erdy = erdy; v.eg = eg; v.esv = esv; v.eres = eres; v.ecnt = ecnt; v.eerr = eerr;
    return v;
  endfunction

  // Behavioural model state
  int   mq[$];
  int   m_rr;
  bit   m_lk;
  int   m_lki;
  bit   m_err;

  initial begin
    vec_t tbl[26];
    logic [3:0] hold_v;
    logic [3:0] acc;

    // hw reset with active inputs: everything must read 0
    req_val = 4'hF; m_op_rdy = 1'b1; m_res_val = 1'b1; rsp_rdy = 4'hF;
    m_res_data = 34'h2DEADBEEF;
    req_data = {32'hD0D1D2D3, 32'h03020405, 32'hB0B1B2B3, 32'hA0A1A2A3};
    #12;
    check_out("rst", 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 34'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    //            rv    opr   resv  rr    sw    ev    erdy  eg esv   eres  cnt   err
    tbl[0]  = mk(4'h4, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h4, 2, 4'h0, 1'b0, 3'd0, 1'b0);
    tbl[1]  = mk(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h4, 1'b1, 3'd1, 1'b0);
    tbl[2]  = mk(4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, 3'd0, 1'b0);
    tbl[3]  = mk(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h8, 3, 4'h0, 1'b0, 3'd0, 1'b0);
    tbl[4]  = mk(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h1, 0, 4'h0, 1'b1, 3'd1, 1'b0);
    tbl[5]  = mk(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h2, 1, 4'h0, 1'b1, 3'd2, 1'b0);
    tbl[6]  = mk(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h4, 2, 4'h0, 1'b1, 3'd3, 1'b0);
    tbl[7]  = mk(4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 0, 4'h8, 1'b0, 3'd4, 1'b0);
    tbl[8]  = mk(4'hF, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 4'h0, 0, 4'h8, 1'b0, 3'd4, 1'b0);
    tbl[9]  = mk(4'hF, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 4'h0, 0, 4'h8, 1'b1, 3'd4, 1'b0);
    tbl[10] = mk(4'hF, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'h8, 3, 4'h1, 1'b1, 3'd3, 1'b0);
    tbl[11] = mk(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h2, 1'b1, 3'd3, 1'b0);
    tbl[12] = mk(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h4, 1'b1, 3'd2, 1'b0);
    tbl[13] = mk(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h8, 1'b1, 3'd1, 1'b0);
    tbl[14] = mk(4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, 3'd0, 1'b0);
    tbl[15] = mk(4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, 3'd0, 1'b1);
    tbl[16] = mk(4'h2, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 1, 4'h0, 1'b0, 3'd0, 1'b1);
    tbl[17] = mk(4'h3, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 1, 4'h0, 1'b0, 3'd0, 1'b1);
    tbl[18] = mk(4'h3, 1'b0, 1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 1, 4'h0, 1'b0, 3'd0, 1'b1);
    tbl[19] = mk(4'h3, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h2, 1, 4'h0, 1'b0, 3'd0, 1'b1);
    tbl[20] = mk(4'h1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h1, 0, 4'h0, 1'b1, 3'd1, 1'b1);
    tbl[21] = mk(4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b1, 3'd2, 1'b1);
    tbl[22] = mk(4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 0, 4'h0, 1'b0, 3'd0, 1'b0);
    tbl[23] = mk(4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 4'h1, 0, 4'h0, 1'b0, 3'd0, 1'b0);
    tbl[24] = mk(4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h1, 1'b1, 3'd1, 1'b0);
    tbl[25] = mk(4'h0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0, 0, 4'h0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 26; i++) begin
      req_val = tbl[i].rv; m_op_rdy = tbl[i].opr; m_res_val = tbl[i].resv;
      rsp_rdy = tbl[i].rr; sw_rst = tbl[i].sw;
      m_res_data = 34'(64'h2DEADBEEF + 64'(i));
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].erdy, slice(tbl[i].eg), tbl[i].esv,
                tbl[i].eres, tbl[i].sw ? 34'h0 : m_res_data, tbl[i].ecnt, tbl[i].eerr);
      @(negedge clk);
    end
    sw_rst = 1'b0; req_val = '0; m_res_val = 1'b0;

    // Randomized phase: fresh hw reset, then compare against the queue model each cycle
    rst_n = 1'b0;
    #1;
    check_out("rst2", 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 34'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_rr = 0; m_lk = 1'b0; m_lki = 0; m_err = 1'b0;
    hold_v = '0; acc = '0;

    for (int c = 0; c < 3000; c++) begin
      bit run, full, elig, nonempty;
      int g, h;
      logic [3:0] erdy, esv;
      logic eres;

      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!(hold_v[i] && !acc[i])) begin
          hold_v[i] = 1'($urandom_range(0, 1));
          req_data[32*i +: 32] = $urandom;
        end
      end
      req_val    = hold_v;
      m_op_rdy   = 1'($urandom_range(0, 1));
      rsp_rdy    = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      m_res_data = {2'($urandom_range(0, 3)), 32'($urandom)};
      m_res_val  = (mq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      sw_rst     = ($urandom_range(0, 199) == 0);
      #1;

      run      = !sw_rst;
      full     = (mq.size() == MO);
      elig     = run && (req_val != 0) && !full;
      nonempty = (mq.size() > 0);
      g = 0;
      if (m_lk) g = m_lki;
      else begin
        for (int k = NR - 1; k >= 0; k--)
          if (req_val[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      end
      h    = nonempty ? mq[0] : 0;
      erdy = (elig && m_op_rdy) ? 4'(1 << g) : 4'h0;
      esv  = (run && m_res_val && nonempty) ? 4'(1 << h) : 4'h0;
      eres = run && nonempty && rsp_rdy[h];
      check_out($sformatf("rnd%0d", c), elig, erdy, slice(g), esv, eres,
                run ? m_res_data : 34'h0, run ? 3'(mq.size()) : 3'd0, run && m_err);

      acc = erdy;
      if (!run) begin
        mq.delete(); m_rr = 0; m_lk = 1'b0; m_err = 1'b0;
      end else begin
        if (m_res_val && !nonempty) m_err = 1'b1;
        if (m_res_val && eres) void'(mq.pop_front());
        if (elig && m_op_rdy) begin
          mq.push_back(g); m_rr = (g + 1) % NR; m_lk = 1'b0;
        end else if (elig) begin
          m_lk = 1'b1; m_lki = g;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
